// File: rtl/secure_key_vault_dbg_if.sv
// secure_key_vault_dbg_if
//   Bundles the key write/read ports and the debug handshake of the key vault.
//   master : provisioning agent / crypto consumer / debug host side
//   slave  : vault side
//   Signals:
//     key_wr_en, key_wr_idx, key_wr_data   key provisioning write
//     key_rd_req, key_rd_idx               read request
//     key_rd_valid, key_rd_hit, key_out    registered read response
//     debug_req, debug_ack                 debug entry handshake
//     debug_status                         {state, slot_valid}, never key bits
//     wr_err                               rejected-write pulse
interface secure_key_vault_dbg_if #(
  parameter int KEY_W    = 128,
  parameter int NUM_KEYS = 4
);
  localparam int IDX_W = $clog2(NUM_KEYS);

  logic                  key_wr_en;
  logic [IDX_W-1:0]      key_wr_idx;
  logic [KEY_W-1:0]      key_wr_data;
  logic                  key_rd_req;
  logic [IDX_W-1:0]      key_rd_idx;
  logic                  key_rd_valid;
  logic                  key_rd_hit;
  logic [KEY_W-1:0]      key_out;
  logic                  debug_req;
  logic                  debug_ack;
  logic [NUM_KEYS+1:0]   debug_status;
  logic                  wr_err;

  modport master (
    output key_wr_en, key_wr_idx, key_wr_data,
    output key_rd_req, key_rd_idx,
    output debug_req,
    input  key_rd_valid, key_rd_hit, key_out,
    input  debug_ack, debug_status, wr_err
  );

  modport slave (
    input  key_wr_en, key_wr_idx, key_wr_data,
    input  key_rd_req, key_rd_idx,
    input  debug_req,
    output key_rd_valid, key_rd_hit, key_out,
    output debug_ack, debug_status, wr_err
  );
endinterface

// File: rtl/secure_key_vault_dbg.sv
// secure_key_vault_dbg
//   Multi-slot secret key store. Debug access is granted only after every slot
//   has been wiped, one slot per cycle. Key material is only ever visible on
//   key_out, and only for a valid hit outside debug entry.
//
//   Ports:
//     clk       clock
//     rst       synchronous active-high reset
//     lock_set  (only with KEY_VAULT_LOCK_EN) permanently lock out debug until rst
//     bus       secure_key_vault_dbg_if.slave: write, read, debug handshake
//
//   Optional feature macro: KEY_VAULT_LOCK_EN
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   NORMAL   | keys readable/writable, debug entry allowed
//   ZEROIZE  | sequential wipe of slot 0..NUM_KEYS-1, accesses rejected
//   DEBUG    | wipe done, debug_ack high, accesses rejected
//   LOCKED   | as NORMAL but debug_req ignored; sticky until rst
module secure_key_vault_dbg #(
  parameter int KEY_W    = 128,
  parameter int NUM_KEYS = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef KEY_VAULT_LOCK_EN
  input  logic lock_set,
`endif
  secure_key_vault_dbg_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'b00,
    ST_ZEROIZE = 2'b01,
    ST_DEBUG   = 2'b10,
    ST_LOCKED  = 2'b11
  } state_t;

  state_t                state_q;
  logic [KEY_W-1:0]      slot_q [NUM_KEYS];
  logic [NUM_KEYS-1:0]   valid_q;
  logic [IDX_W-1:0]      wipe_cnt_q;
  logic                  rd_valid_q;
  logic                  rd_hit_q;
  logic [KEY_W-1:0]      key_out_q;
  logic                  debug_ack_q;
  logic                  wr_err_q;

  logic lock_req;
  logic enter_dbg;
  logic access_ok;
  logic rejected;

`ifdef KEY_VAULT_LOCK_EN
  assign lock_req = lock_set && (state_q == ST_NORMAL);
`else
  assign lock_req = 1'b0;
`endif

  // Lock wins over a same-cycle debug request.
  assign enter_dbg = (state_q == ST_NORMAL) && bus.debug_req && !lock_req;
  // The cycle that samples debug entry drops any access.
  assign access_ok = ((state_q == ST_NORMAL) || (state_q == ST_LOCKED)) && !enter_dbg;
  assign rejected  = (state_q == ST_ZEROIZE) || (state_q == ST_DEBUG);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      valid_q     <= '0;
      wipe_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_hit_q    <= 1'b0;
      key_out_q   <= '0;
      debug_ack_q <= 1'b0;
      wr_err_q    <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      key_out_q  <= '0;
      wr_err_q   <= 1'b0;

      if (bus.key_wr_en) begin
        if (access_ok) begin
          slot_q[bus.key_wr_idx]  <= bus.key_wr_data;
          valid_q[bus.key_wr_idx] <= 1'b1;
        end else begin
          wr_err_q <= 1'b1;
        end
      end

      // Read sees pre-edge contents, so a same-cycle write returns old data.
      if (bus.key_rd_req) begin
        if (access_ok) begin
          rd_valid_q <= 1'b1;
          rd_hit_q   <= valid_q[bus.key_rd_idx];
          key_out_q  <= valid_q[bus.key_rd_idx] ? slot_q[bus.key_rd_idx] : '0;
        end else if (rejected) begin
          rd_valid_q <= 1'b1;
        end
      end

      case (state_q)
        ST_NORMAL: begin
          debug_ack_q <= 1'b0;
          if (lock_req) begin
            state_q <= ST_LOCKED;
          end else if (bus.debug_req) begin
            state_q    <= ST_ZEROIZE;
            wipe_cnt_q <= '0;
          end
        end
        ST_ZEROIZE: begin
          // Not abortable: debug_req is ignored until the last slot is cleared.
          slot_q[wipe_cnt_q]  <= '0;
          valid_q[wipe_cnt_q] <= 1'b0;
          if (wipe_cnt_q == LAST_IDX) begin
            state_q     <= ST_DEBUG;
            debug_ack_q <= 1'b1;
          end else begin
            wipe_cnt_q <= wipe_cnt_q + IDX_W'(1);
          end
        end
        ST_DEBUG: begin
          if (!bus.debug_req) begin
            state_q     <= ST_NORMAL;
            debug_ack_q <= 1'b0;
          end else begin
            debug_ack_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          debug_ack_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_NORMAL;
          debug_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_rd_valid = rd_valid_q;
  assign bus.key_rd_hit   = rd_hit_q;
  assign bus.key_out      = key_out_q;
  assign bus.debug_ack    = debug_ack_q;
  assign bus.debug_status = {state_q, valid_q};
  assign bus.wr_err       = wr_err_q;

endmodule

// File: tb/tb_secure_key_vault_dbg.sv
module tb_secure_key_vault_dbg;

  localparam int KEY_W    = 128;
  localparam int NUM_KEYS = 4;

  localparam logic [127:0] K0  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] K1  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] K2  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
  localparam logic [127:0] K2B = 128'hCAFE_F00D_AAAA_5555_0F0F_F0F0_3C3C_C3C3;
  localparam logic [127:0] K3  = 128'hFFFF_0000_ABCD_EF01_2345_6789_8888_9999;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  secure_key_vault_dbg_if #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS)) bus ();

`ifdef KEY_VAULT_LOCK_EN
  logic lock_set;
  secure_key_vault_dbg #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS)) dut (
    .clk(clk), .rst(rst), .lock_set(lock_set), .bus(bus)
  );
`else
  secure_key_vault_dbg #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.key_wr_en   = 1'b0;
    bus.key_wr_idx  = '0;
    bus.key_wr_data = '0;
    bus.key_rd_req  = 1'b0;
    bus.key_rd_idx  = '0;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [127:0] data);
    bus.key_wr_en   = 1'b1;
    bus.key_wr_idx  = idx;
    bus.key_wr_data = data;
    tick();
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] idx,
                        input logic hit, input logic [127:0] data);
    bus.key_rd_req = 1'b1;
    bus.key_rd_idx = idx;
    tick();
    idle();
    check({tag, "_valid"}, 128'(bus.key_rd_valid), 128'(1'b1));
    check({tag, "_hit"},   128'(bus.key_rd_hit),   128'(hit));
    check({tag, "_out"},   bus.key_out,            data);
  endtask

  // Expected debug_status after each of the 5 edges following debug_req.
  logic [5:0] wipe_stat [5];
  logic [5:0] wipe_stat_rel [6];
  logic [5:0] s;

  initial begin
    n_chk = 0;
    n_bad = 0;
    wipe_stat[0] = 6'b01_1111;
    wipe_stat[1] = 6'b01_1110;
    wipe_stat[2] = 6'b01_1100;
    wipe_stat[3] = 6'b01_1000;
    wipe_stat[4] = 6'b10_0000;

    rst = 1'b1;
    bus.debug_req = 1'b0;
`ifdef KEY_VAULT_LOCK_EN
    lock_set = 1'b0;
`endif
    idle();
    tick();
    tick();
    check("rst_status", 128'(bus.debug_status), 128'(6'b0));
    check("rst_valid",  128'(bus.key_rd_valid), 128'(1'b0));
    check("rst_ack",    128'(bus.debug_ack),    128'(1'b0));
    check("rst_wrerr",  128'(bus.wr_err),       128'(1'b0));
    check("rst_out",    bus.key_out,            128'(0));
    rst = 1'b0;
    tick();

    // basic write/read
    wr(2'd2, K2);
    check("wr2_status", 128'(bus.debug_status), 128'(6'b00_0100));
    rd_chk("rd2", 2'd2, 1'b1, K2);
    tick();
    check("rd_pulse_valid", 128'(bus.key_rd_valid), 128'(1'b0));
    check("rd_pulse_out",   bus.key_out,            128'(0));
    rd_chk("rd1_miss", 2'd1, 1'b0, 128'(0));

    // same-cycle write and read of one slot returns old data
    bus.key_wr_en = 1'b1; bus.key_wr_idx = 2'd2; bus.key_wr_data = K2B;
    bus.key_rd_req = 1'b1; bus.key_rd_idx = 2'd2;
    tick();
    idle();
    check("rw_old", bus.key_out, K2);
    rd_chk("rd2_new", 2'd2, 1'b1, K2B);

    // fill all slots and enter debug
    wr(2'd0, K0);
    wr(2'd1, K1);
    wr(2'd3, K3);
    check("fill_status", 128'(bus.debug_status), 128'(6'b00_1111));
    bus.debug_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("wipe_ack%0d", i), 128'(bus.debug_ack), 128'(i == 4));
      check($sformatf("wipe_st%0d", i), 128'(bus.debug_status), 128'(wipe_stat[i]));
      check($sformatf("wipe_out%0d", i), bus.key_out, 128'(0));
    end

    // accesses in DEBUG are rejected
    bus.key_wr_en = 1'b1; bus.key_wr_idx = 2'd0; bus.key_wr_data = K0;
    tick();
    idle();
    check("dbg_wrerr",  128'(bus.wr_err),       128'(1'b1));
    check("dbg_wr_st",  128'(bus.debug_status), 128'(6'b10_0000));
    tick();
    check("dbg_wrerr_pulse", 128'(bus.wr_err),  128'(1'b0));
    rd_chk("dbg_rd0", 2'd0, 1'b0, 128'(0));

    bus.debug_req = 1'b0;
    tick();
    check("exit_ack", 128'(bus.debug_ack),    128'(1'b0));
    check("exit_st",  128'(bus.debug_status), 128'(6'b00_0000));
    rd_chk("post_rd3", 2'd3, 1'b0, 128'(0));

    // debug_req dropped mid-wipe; read during wipe answers miss
    wr(2'd1, K1);
    bus.debug_req = 1'b1;
    tick();
    tick();
    bus.debug_req = 1'b0;
    bus.key_rd_req = 1'b1; bus.key_rd_idx = 2'd1;
    tick();
    idle();
    check("zrd_valid", 128'(bus.key_rd_valid), 128'(1'b1));
    check("zrd_hit",   128'(bus.key_rd_hit),   128'(1'b0));
    check("zrd_out",   bus.key_out,            128'(0));
    check("zrd_st",    128'(bus.debug_status), 128'(6'b01_0000));
    tick();
    check("abort_ack3", 128'(bus.debug_ack), 128'(1'b0));
    tick();
    check("abort_ack4", 128'(bus.debug_ack),    128'(1'b1));
    check("abort_st4",  128'(bus.debug_status), 128'(6'b10_0000));
    tick();
    check("abort_ack5", 128'(bus.debug_ack),    128'(1'b0));
    check("abort_st5",  128'(bus.debug_status), 128'(6'b00_0000));
    rd_chk("abort_rd1", 2'd1, 1'b0, 128'(0));

    // same-cycle write/read with debug entry: write and read dropped
    bus.key_wr_en = 1'b1; bus.key_wr_idx = 2'd0; bus.key_wr_data = K0;
    bus.key_rd_req = 1'b1; bus.key_rd_idx = 2'd0;
    bus.debug_req = 1'b1;
    tick();
    idle();
    check("entry_wrerr", 128'(bus.wr_err),       128'(1'b1));
    check("entry_rdv",   128'(bus.key_rd_valid), 128'(1'b0));
    check("entry_st",    128'(bus.debug_status), 128'(6'b01_0000));
    tick();
    // reset mid-wipe with traffic present
    rst = 1'b1;
    bus.key_wr_en = 1'b1; bus.key_wr_idx = 2'd3; bus.key_wr_data = K3;
    bus.key_rd_req = 1'b1; bus.key_rd_idx = 2'd3;
    tick();
    check("mrst_st",    128'(bus.debug_status), 128'(6'b0));
    check("mrst_ack",   128'(bus.debug_ack),    128'(1'b0));
    check("mrst_wrerr", 128'(bus.wr_err),       128'(1'b0));
    check("mrst_rdv",   128'(bus.key_rd_valid), 128'(1'b0));
    check("mrst_out",   bus.key_out,            128'(0));
    idle();
    bus.debug_req = 1'b0;
    rst = 1'b0;
    tick();
    wr(2'd3, K3);
    rd_chk("after_rst_rd3", 2'd3, 1'b1, K3);

`ifdef KEY_VAULT_LOCK_EN
    // lock, then debug_req is ignored; same-cycle lock and debug_req: lock wins
    lock_set = 1'b1;
    bus.debug_req = 1'b1;
    tick();
    lock_set = 1'b0;
    check("lock_st", 128'(bus.debug_status), 128'(6'b11_1000));
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("lock_ack%0d", i), 128'(bus.debug_ack), 128'(1'b0));
    end
    check("lock_st_hold", 128'(bus.debug_status), 128'(6'b11_1000));
    rd_chk("lock_rd3", 2'd3, 1'b1, K3);
    bus.debug_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
